sram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single 32-bit SRAM bus adapter between NUM_REQ Avalon-MM style requesters
//  (e.g. rasterizer framebuffer writer, VGA scanout reader, host bridge). Grants one transfer at a time.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/arb_id_fifo.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned DATA_W  = 32;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Single-step modulo wrap; idx is always < 2*num where it is used.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned num);
    return (idx >= num) ? (idx - num) : idx;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for reads awaiting their data beat.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM bus adapter port among NUM_REQ requesters,
// with in-order routing of returning read data back to the issuing requester.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_DEPTH = 4,
  parameter int unsigned ADDR_W   = 26
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]           mst_address,
  output logic                        mst_read,
  output logic                        mst_write,
  output logic [DATA_W-1:0]           mst_writedata,
  input  logic                        mst_waitrequest,
  input  logic [DATA_W-1:0]           mst_readdata,
  input  logic                        mst_readdatavalid,
  output logic                        err_unexpected
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ID_W-1:0]   r_gnt;
  logic [ID_W-1:0]   w_gnt_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_rr_nxt;
  logic              r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [ID_W-1:0]    w_pick;
  logic               w_any;
  logic               w_acc;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ID_W-1:0]    w_fifo_dout;

  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];

  // Split the flattened request buses into per-requester lanes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_addr[i]  = req_address[i*ADDR_W +: ADDR_W];
      w_wdata[i] = req_writedata[i*DATA_W +: DATA_W];
    end
  end

  // Reads are held off while every ID slot is in use; writes never are.
  assign w_elig = req_write | (req_read & {NUM_REQ{~w_fifo_full}});

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    int unsigned v_idx;
    v_idx  = 0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = rr_wrap(32'(r_rr_ptr) + k, NUM_REQ);
      if (!w_any && w_elig[ID_W'(v_idx)]) begin
        w_any  = 1'b1;
        w_pick = ID_W'(v_idx);
      end
    end
  end

  // Arbiter next state and master-side muxing.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_rr_nxt        = r_rr_ptr;
    w_push          = 1'b0;
    w_acc           = 1'b0;
    req_waitrequest = '1;
    mst_read        = 1'b0;
    mst_write       = 1'b0;
    mst_address     = w_addr[r_gnt];
    mst_writedata   = w_wdata[r_gnt];
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Write wins when a requester raises both strobes.
        mst_write              = req_write[r_gnt];
        mst_read               = req_read[r_gnt] & ~req_write[r_gnt];
        req_waitrequest[r_gnt] = mst_waitrequest;
        w_acc                  = (mst_read | mst_write) & ~mst_waitrequest;
        if (w_acc) begin
          w_push      = mst_read;
          w_rr_nxt    = ID_W'(rr_wrap(32'(r_gnt) + 32'd1, NUM_REQ));
          w_state_nxt = ARB_IDLE;
        end else if (!(mst_read | mst_write)) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Arbiter state, current grant and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ARB_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Route each returning read beat to the oldest outstanding requester.
  always_comb begin
    req_readdatavalid = '0;
    w_pop             = mst_readdatavalid & ~w_fifo_empty;
    if (w_pop) req_readdatavalid[w_fifo_dout] = 1'b1;
  end

  assign req_readdata = mst_readdata;

  // Sticky flag for a read beat arriving with nothing outstanding.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (mst_readdatavalid && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign err_unexpected = r_err;

  arb_id_fifo #(
    .DEPTH (ID_DEPTH),
    .W     (ID_W)
  ) u_id_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_gnt),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of requesters and the bus adapter.
module tb_sram_port_arbiter;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned ID_DEPTH = 4;
  localparam int unsigned ADDR_W   = 26;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*32-1:0]     req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [31:0]               req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic [ADDR_W-1:0]         mst_address;
  logic                      mst_read;
  logic                      mst_write;
  logic [31:0]               mst_writedata;
  logic                      mst_waitrequest;
  logic [31:0]               mst_readdata;
  logic                      mst_readdatavalid;
  logic                      err_unexpected;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sram_port_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_DEPTH (ID_DEPTH),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .mst_address       (mst_address),
    .mst_read          (mst_read),
    .mst_write         (mst_write),
    .mst_writedata     (mst_writedata),
    .mst_waitrequest   (mst_waitrequest),
    .mst_readdata      (mst_readdata),
    .mst_readdatavalid (mst_readdatavalid),
    .err_unexpected    (err_unexpected)
  );

  task automatic clear_inputs();
    req_read          = '0;
    req_write         = '0;
    req_address       = '0;
    req_writedata     = '0;
    mst_waitrequest   = 1'b0;
    mst_readdata      = '0;
    mst_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    req_write         = '1;
    mst_readdatavalid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_tests++; if (req_waitrequest !== 2'b11) begin n_fail++; $display("FAIL reset_waitreq got=%b exp=11", req_waitrequest); end
    n_tests++; if (mst_write !== 1'b0 || mst_read !== 1'b0) begin n_fail++; $display("FAIL reset_mst_strobes got=%b%b exp=00", mst_read, mst_write); end
    n_tests++; if (req_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL reset_rdv got=%b exp=00", req_readdatavalid); end
    n_tests++; if (err_unexpected !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_unexpected); end
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clock);
    req_write = 2'b10;
    req_address[ADDR_W +: ADDR_W] = ADDR_W'(32'h100);
    req_writedata[32 +: 32] = 32'hDEADBEEF;
    #1;
    n_tests++; if (mst_write !== 1'b0 || req_waitrequest !== 2'b11) begin n_fail++; $display("FAIL sw_arb_cycle got wr=%b wait=%b exp wr=0 wait=11", mst_write, req_waitrequest); end
    @(negedge clock); #1;
    n_tests++; if (mst_write !== 1'b1 || mst_read !== 1'b0) begin n_fail++; $display("FAIL sw_strobe got rd=%b wr=%b exp rd=0 wr=1", mst_read, mst_write); end
    n_tests++; if (mst_address !== ADDR_W'(32'h100)) begin n_fail++; $display("FAIL sw_addr got=%h exp=100", mst_address); end
    n_tests++; if (mst_writedata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_data got=%h exp=deadbeef", mst_writedata); end
    n_tests++; if (req_waitrequest !== 2'b01) begin n_fail++; $display("FAIL sw_waitreq got=%b exp=01", req_waitrequest); end
    @(negedge clock);
    req_write = '0;
    #1;
    n_tests++; if (mst_write !== 1'b0) begin n_fail++; $display("FAIL sw_after got=%b exp=0", mst_write); end
  endtask

  task automatic test_rr_alternate();
    int exp_id;
    int got_id;
    int grants;
    do_reset();
    exp_id = 0;
    grants = 0;
    @(negedge clock);
    req_write = 2'b11;
    req_address   = {ADDR_W'(32'h600), ADDR_W'(32'h500)};
    req_writedata = {32'h6666_0001, 32'h5555_0000};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      if (mst_write) begin
        got_id = (req_waitrequest == 2'b10) ? 0 : (req_waitrequest == 2'b01) ? 1 : -1;
        n_tests++; if (got_id != exp_id) begin n_fail++; $display("FAIL rr_grant idx=%0d got=%0d exp=%0d", grants, got_id, exp_id); end
        n_tests++; if (mst_address !== ADDR_W'(32'h500 + 32'(exp_id) * 32'h100)) begin n_fail++; $display("FAIL rr_addr idx=%0d got=%h", grants, mst_address); end
        exp_id = (exp_id + 1) % NUM_REQ;
        grants++;
      end
    end
    n_tests++; if (grants != 4) begin n_fail++; $display("FAIL rr_count got=%0d exp=4", grants); end
    @(negedge clock);
    req_write = '0;
  endtask

  task automatic test_read_order();
    do_reset();
    @(negedge clock);
    req_read = 2'b01;
    req_address[0 +: ADDR_W] = ADDR_W'(32'h40);
    @(negedge clock); #1;
    n_tests++; if (mst_read !== 1'b1 || mst_address !== ADDR_W'(32'h40) || req_waitrequest !== 2'b10) begin n_fail++; $display("FAIL rd0_issue got rd=%b addr=%h wait=%b", mst_read, mst_address, req_waitrequest); end
    @(negedge clock);
    req_read = 2'b10;
    req_address[ADDR_W +: ADDR_W] = ADDR_W'(32'h80);
    @(negedge clock); #1;
    n_tests++; if (mst_read !== 1'b1 || mst_address !== ADDR_W'(32'h80) || req_waitrequest !== 2'b01) begin n_fail++; $display("FAIL rd1_issue got rd=%b addr=%h wait=%b", mst_read, mst_address, req_waitrequest); end
    @(negedge clock);
    req_read = '0;
    mst_readdatavalid = 1'b1;
    mst_readdata = 32'h11111111;
    #1;
    n_tests++; if (req_readdatavalid !== 2'b01 || req_readdata !== 32'h11111111) begin n_fail++; $display("FAIL rd_ret0 got v=%b d=%h exp v=01 d=11111111", req_readdatavalid, req_readdata); end
    @(negedge clock);
    mst_readdata = 32'h22222222;
    #1;
    n_tests++; if (req_readdatavalid !== 2'b10 || req_readdata !== 32'h22222222) begin n_fail++; $display("FAIL rd_ret1 got v=%b d=%h exp v=10 d=22222222", req_readdatavalid, req_readdata); end
    @(negedge clock);
    mst_readdatavalid = 1'b0;
    #1;
    n_tests++; if (req_readdatavalid !== 2'b00 || err_unexpected !== 1'b0) begin n_fail++; $display("FAIL rd_done got v=%b err=%b exp v=00 err=0", req_readdatavalid, err_unexpected); end
  endtask

  task automatic test_fifo_full();
    int acc;
    do_reset();
    acc = 0;
    @(negedge clock);
    req_read = 2'b01;
    for (int c = 0; c < 20 && acc < int'(ID_DEPTH); c++) begin
      if (c > 0) @(negedge clock);
      req_address[0 +: ADDR_W] = ADDR_W'(32'h1000 + 32'(acc) * 4);
      #1;
      if (mst_read && !req_waitrequest[0]) acc++;
    end
    n_tests++; if (acc != int'(ID_DEPTH)) begin n_fail++; $display("FAIL full_fill got=%0d exp=%0d", acc, ID_DEPTH); end
    repeat (3) begin
      @(negedge clock); #1;
      n_tests++; if (req_waitrequest !== 2'b11 || mst_read !== 1'b0) begin n_fail++; $display("FAIL full_stall got wait=%b rd=%b exp wait=11 rd=0", req_waitrequest, mst_read); end
    end
    @(negedge clock);
    req_write = 2'b10;
    req_address[ADDR_W +: ADDR_W] = ADDR_W'(32'h200);
    @(negedge clock); #1;
    n_tests++; if (mst_write !== 1'b1 || req_waitrequest !== 2'b01 || mst_address !== ADDR_W'(32'h200)) begin n_fail++; $display("FAIL full_write got wr=%b wait=%b addr=%h", mst_write, req_waitrequest, mst_address); end
    @(negedge clock);
    req_write = '0;
    #1;
    n_tests++; if (req_waitrequest !== 2'b11) begin n_fail++; $display("FAIL full_stall2 got=%b exp=11", req_waitrequest); end
    @(negedge clock);
    mst_readdatavalid = 1'b1;
    mst_readdata = 32'hA0A0A0A0;
    #1;
    n_tests++; if (req_readdatavalid !== 2'b01) begin n_fail++; $display("FAIL full_pop got=%b exp=01", req_readdatavalid); end
    @(negedge clock);
    mst_readdatavalid = 1'b0;
    @(negedge clock); #1;
    n_tests++; if (mst_read !== 1'b1 || req_waitrequest !== 2'b10) begin n_fail++; $display("FAIL full_unblock got rd=%b wait=%b exp rd=1 wait=10", mst_read, req_waitrequest); end
    @(negedge clock);
    req_read = '0;
    for (int k = 0; k < int'(ID_DEPTH); k++) begin
      if (k > 0) @(negedge clock);
      mst_readdatavalid = 1'b1;
      mst_readdata = $urandom;
      #1;
      n_tests++; if (req_readdatavalid !== 2'b01 || req_readdata !== mst_readdata) begin n_fail++; $display("FAIL full_drain k=%0d got v=%b d=%h", k, req_readdatavalid, req_readdata); end
    end
    @(negedge clock);
    mst_readdatavalid = 1'b0;
  endtask

  task automatic test_unexpected();
    @(negedge clock);
    mst_readdatavalid = 1'b1;
    mst_readdata = 32'hBAD0BAD0;
    #1;
    n_tests++; if (req_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL unexp_rdv got=%b exp=00", req_readdatavalid); end
    n_tests++; if (err_unexpected !== 1'b0) begin n_fail++; $display("FAIL unexp_pre got=%b exp=0", err_unexpected); end
    @(negedge clock);
    mst_readdatavalid = 1'b0;
    #1;
    n_tests++; if (err_unexpected !== 1'b1) begin n_fail++; $display("FAIL unexp_set got=%b exp=1", err_unexpected); end
    repeat (4) @(negedge clock);
    #1;
    n_tests++; if (err_unexpected !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky got=%b exp=1", err_unexpected); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    @(negedge clock);
    req_read = 2'b01;
    req_address[0 +: ADDR_W] = ADDR_W'(32'h10);
    @(negedge clock); #1;
    n_tests++; if (mst_read !== 1'b1 || req_waitrequest !== 2'b10) begin n_fail++; $display("FAIL rmg_first got rd=%b wait=%b", mst_read, req_waitrequest); end
    @(negedge clock);
    req_read = 2'b10;
    req_address[ADDR_W +: ADDR_W] = ADDR_W'(32'h300);
    mst_waitrequest = 1'b1;
    @(negedge clock); #1;
    n_tests++; if (mst_read !== 1'b1 || req_waitrequest !== 2'b11) begin n_fail++; $display("FAIL rmg_stall got rd=%b wait=%b exp rd=1 wait=11", mst_read, req_waitrequest); end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    req_read = '0;
    req_write = 2'b11;
    mst_waitrequest = 1'b0;
    #1;
    n_tests++; if (mst_read !== 1'b0 || mst_write !== 1'b0 || req_waitrequest !== 2'b11) begin n_fail++; $display("FAIL rmg_after got rd=%b wr=%b wait=%b", mst_read, mst_write, req_waitrequest); end
    n_tests++; if (err_unexpected !== 1'b0) begin n_fail++; $display("FAIL rmg_err_clr got=%b exp=0", err_unexpected); end
    @(negedge clock); #1;
    n_tests++; if (mst_write !== 1'b1 || req_waitrequest !== 2'b10) begin n_fail++; $display("FAIL rmg_rr_ptr got wr=%b wait=%b exp wr=1 wait=10", mst_write, req_waitrequest); end
    @(negedge clock);
    req_write = '0;
    mst_readdatavalid = 1'b1;
    #1;
    n_tests++; if (req_readdatavalid !== 2'b00) begin n_fail++; $display("FAIL rmg_fifo_empty got=%b exp=00", req_readdatavalid); end
    @(negedge clock);
    mst_readdatavalid = 1'b0;
    #1;
    n_tests++; if (err_unexpected !== 1'b1) begin n_fail++; $display("FAIL rmg_stale_err got=%b exp=1", err_unexpected); end
  endtask

  // Randomized traffic: requesters hold one transaction until accepted; the
  // adapter returns reads in order after a random delay.
  task automatic test_random();
    bit          pend   [NUM_REQ];
    bit          pw     [NUM_REQ];
    logic [ADDR_W-1:0] pa [NUM_REQ];
    logic [31:0] pd     [NUM_REQ];
    int          others [NUM_REQ];
    int          q_ids[$];
    int          adapter_cnt;
    int          g;
    int          nlow;
    int          exp_id;
    bit          ret;
    bit          drained;
    logic [NUM_REQ-1:0] exp_v;
    do_reset();
    adapter_cnt = 0;
    drained = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; others[i] = 0;
    end
    for (int cyc = 0; cyc < 3000 && !drained; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && cyc < 800 && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          pw[i]     = 1'($urandom_range(0, 1));
          pa[i]     = ADDR_W'($urandom);
          pd[i]     = $urandom;
          others[i] = 0;
        end
        req_write[i] = pend[i] & pw[i];
        req_read[i]  = pend[i] & ~pw[i];
        req_address[i*ADDR_W +: ADDR_W] = pa[i];
        req_writedata[i*32 +: 32]       = pd[i];
      end
      mst_waitrequest   = ($urandom_range(0, 2) == 0);
      ret               = (adapter_cnt > 0) && ($urandom_range(0, 1) == 1);
      mst_readdatavalid = ret;
      mst_readdata      = $urandom;
      #1;
      if (ret) begin
        exp_id = q_ids.pop_front();
        adapter_cnt--;
        exp_v = '0;
        exp_v[exp_id] = 1'b1;
        n_tests++; if (req_readdatavalid !== exp_v || req_readdata !== mst_readdata) begin n_fail++; $display("FAIL rand_ret cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, req_readdatavalid, req_readdata, exp_v, mst_readdata); end
      end else begin
        n_tests++; if (req_readdatavalid !== '0) begin n_fail++; $display("FAIL rand_noret cyc=%0d got=%b exp=00", cyc, req_readdatavalid); end
      end
      if ((mst_read || mst_write) && !mst_waitrequest) begin
        g = -1;
        nlow = 0;
        for (int i = 0; i < NUM_REQ; i++) if (!req_waitrequest[i]) begin g = i; nlow++; end
        n_tests++; if (nlow != 1 || g < 0 || !pend[g]) begin n_fail++; $display("FAIL rand_owner cyc=%0d wait=%b", cyc, req_waitrequest); end
        if (nlow == 1 && g >= 0 && pend[g]) begin
          n_tests++; if (mst_write !== pw[g] || mst_read !== !pw[g] || mst_address !== pa[g]) begin n_fail++; $display("FAIL rand_xfer cyc=%0d req=%0d got rd=%b wr=%b a=%h exp wr=%b a=%h", cyc, g, mst_read, mst_write, mst_address, pw[g], pa[g]); end
          if (pw[g]) begin
            n_tests++; if (mst_writedata !== pd[g]) begin n_fail++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, mst_writedata, pd[g]); end
            n_tests++; if (others[g] > NUM_REQ - 1) begin n_fail++; $display("FAIL rand_fair cyc=%0d req=%0d waited=%0d max=%0d", cyc, g, others[g], NUM_REQ - 1); end
          end else begin
            n_tests++; if (q_ids.size() >= int'(ID_DEPTH)) begin n_fail++; $display("FAIL rand_overfill cyc=%0d outstanding=%0d max=%0d", cyc, q_ids.size(), ID_DEPTH); end
            q_ids.push_back(g);
            adapter_cnt++;
          end
          for (int j = 0; j < NUM_REQ; j++) if (j != g && pend[j]) others[j]++;
          pend[g] = 1'b0;
        end
      end else begin
        n_tests++; if (req_waitrequest !== '1) begin n_fail++; $display("FAIL rand_idle_wait cyc=%0d got=%b exp=11", cyc, req_waitrequest); end
      end
      n_tests++; if (err_unexpected !== 1'b0) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=0", cyc, err_unexpected); end
      drained = (cyc >= 800) && (adapter_cnt == 0);
      for (int i = 0; i < NUM_REQ; i++) if (pend[i]) drained = 1'b0;
    end
    n_tests++; if (!drained) begin n_fail++; $display("FAIL rand_timeout outstanding=%0d exp=0", adapter_cnt); end
    @(negedge clock);
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_rr_alternate();
    test_read_order();
    test_fifo_full();
    test_unexpected();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
